sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO; next generation of the team's 8x16 FIFO.
//   Adds configurable width/depth, occupancy count, programmable almost-full/empty flags,
//   overflow/underflow error pulses and optional first-word-fall-through (FWFT) read mode.
//   Sits between a producer and a consumer in the same clock domain as a rate-matching buffer.
// PARAMETERS
//   DATA_W     8   data word width in bits
//   DEPTH      16  number of entries; must be a power of 2, >= 4
//   AF_THRESH  12  Almost_full asserted when Count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  4   Almost_empty asserted when Count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0   0 = registered read (1-cycle latency); 1 = first-word-fall-through
//   (local) ADDR_W = $clog2(DEPTH)
// PORTS
//   clk           in   1         rising-edge clock
//   rst           in   1         asynchronous reset, active-high
//   W_en          in   1         write request
//   W_data        in   DATA_W    write data, sampled on the clk edge where a write is accepted
//   R_en          in   1         read request
//   R_data        out  DATA_W    read data
//   Empty         out  1         Count == 0
//   Full          out  1         Count == DEPTH
//   Almost_empty  out  1         Count <= AE_THRESH
//   Almost_full   out  1         Count >= AF_THRESH
//   Count         out  ADDR_W+1  current occupancy, 0..DEPTH
//   Overflow      out  1         1-cycle pulse: write rejected
//   Underflow     out  1         1-cycle pulse: read rejected
// BEHAVIOUR
//   - Reset (async, rst=1): wr_ptr=rd_ptr=0, Count=0, Empty=1, Full=0, Almost_empty=1,
//     Almost_full=0, R_data=0, Overflow=Underflow=0. Memory contents not reset.
//     Assertion mid-operation discards all stored data immediately.
//   - Pointers are ADDR_W+1 bits; the MSB is the wrap bit. Memory index = ptr[ADDR_W-1:0].
//     Count = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)). Pointers wrap DEPTH-1 -> 0 with no gap.
//   - Flags and Count are decoded from registered pointers; they reflect an accepted
//     operation on the cycle after its clk edge.
//   - Write accepted = W_en & (~Full | rd_acc); stores W_data at wr_ptr, wr_ptr += 1.
//   - Read accepted rd_acc = R_en & ~Empty; rd_ptr += 1.
//   - Full with W_en & R_en: both accepted, Count stays DEPTH, Full stays 1.
//   - Empty with W_en & R_en: write accepted, read rejected (Underflow=1), Count -> 1.
//   - Otherwise, simultaneous accepted read and write leave Count unchanged.
//   - Overflow registered: 1 on the cycle after an edge where W_en=1 was not accepted.
//     Underflow registered: 1 on the cycle after an edge where R_en=1 was not accepted.
//     A rejected op changes no pointer and no memory entry.
//   - FWFT=0: on an accepted read, R_data <= mem[rd_ptr] at that edge (valid from the next
//     cycle); R_data holds its value otherwise, including on rejected reads.
//   - FWFT=1: R_data = mem[rd_ptr] continuously while ~Empty (head visible before R_en);
//     R_en pops the head. R_data is 0 while Empty. Write-to-R_data latency 1 cycle when Empty.
//   - Read of an entry being written in the same cycle never occurs (Empty blocks the read).
// TESTING
//   1 Reset: rst=1 mid-stream with Count=7 -> next cycle Count=0, Empty=1, Almost_empty=1, R_data=0.
//   2 Fill: 16 writes of 0..15 (defaults) -> Almost_full rises after the 12th write,
//     Full=1 and Count=16 after the 16th; a 17th write -> Overflow pulse, Count stays 16.
//   3 Drain (FWFT=0): 16 reads -> R_data = 0..15 in order, one cycle after each R_en;
//     Empty=1 after the 16th; a 17th read -> Underflow pulse, R_data holds 15.
//   4 Wrap: repeat fill/drain three times -> data order intact each pass, ptr wrap bit toggles.
//   5 Simultaneous: at Full, W_en=R_en=1 with W_data=0xAA -> Count=16, no Overflow, 0xAA read
//     last; at Empty, both set -> Underflow pulse, Count=1.
//   6 FWFT=1, DATA_W=16, DEPTH=8: write 0x1234 -> R_data=0x1234 next cycle with no R_en;
//     R_en=1 -> Empty=1 and R_data=0 the following cycle.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus for sync_fifo_param.
//   master: the producer/consumer side. It drives W_en, W_data and R_en, and it observes
//           data, flags, count and error pulses.
//   slave : the FIFO side.
//   W_en/W_data   write request and data
//   R_en/R_data   read request and data
//   Empty, Full, Almost_empty, Almost_full, Count   occupancy status
//   Overflow, Underflow                             1-cycle rejected-operation pulses
interface sync_fifo_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              W_en;
  logic [DATA_W-1:0] W_data;
  logic              R_en;
  logic [DATA_W-1:0] R_data;
  logic              Empty;
  logic              Full;
  logic              Almost_empty;
  logic              Almost_full;
  logic [ADDR_W:0]   Count;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output W_en, W_data, R_en,
    input  R_data, Empty, Full, Almost_empty, Almost_full, Count, Overflow, Underflow
  );

  modport slave (
    input  W_en, W_data, R_en,
    output R_data, Empty, Full, Almost_empty, Almost_full, Count, Overflow, Underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty flags,
// overflow/underflow pulses and optional first-word-fall-through read.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; discards all stored data
//   bus  sync_fifo_param_if.slave (write/read handshakes, data, status flags)
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 4,
  parameter bit          FWFT      = 1'b0
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AfCnt    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AeCnt    = (ADDR_W + 1)'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // The extra pointer MSB is the wrap bit, which separates the full case from the empty case.
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, underflow_q;
  logic [ADDR_W:0]   count;
  logic              empty, full;
  logic              wr_acc, rd_acc;
  logic [ADDR_W-1:0] wr_idx, rd_idx;

  assign count  = wr_ptr_q - rd_ptr_q;
  assign empty  = (count == '0);
  assign full   = (count == DepthCnt);
  assign wr_idx = wr_ptr_q[ADDR_W-1:0];
  assign rd_idx = rd_ptr_q[ADDR_W-1:0];

  // When the FIFO is full, a read on the same edge frees the slot that the write reuses.
  assign rd_acc = bus.R_en & ~empty;
  assign wr_acc = bus.W_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= bus.W_en & ~wr_acc;
      underflow_q <= bus.R_en & ~rd_acc;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_idx] <= bus.W_data;
  end

  generate
    if (FWFT) begin : g_fwft
      // The head is visible combinationally whenever the FIFO holds data.
      assign bus.R_data = empty ? '0 : mem_q[rd_idx];
    end else begin : g_reg
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (rd_acc) begin
          rdata_q <= mem_q[rd_idx];
        end
      end
      assign bus.R_data = rdata_q;
    end
  endgenerate

  assign bus.Count        = count;
  assign bus.Empty        = empty;
  assign bus.Full         = full;
  assign bus.Almost_empty = (count <= AeCnt);
  assign bus.Almost_full  = (count >= AfCnt);
  assign bus.Overflow     = overflow_q;
  assign bus.Underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  logic clk;
  logic rst;

  sync_fifo_param_if #(.DATA_W(8),  .DEPTH(16)) m_if ();
  sync_fifo_param_if #(.DATA_W(16), .DEPTH(8))  f_if ();

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(m_if)
  );

  sync_fifo_param #(
    .DATA_W(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)
  ) dut_fwft (
    .clk(clk),
    .rst(rst),
    .bus(f_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         w_en;
    logic [7:0] w_data;
    bit         r_en;
    int         cnt;
    bit         ovf;
    bit         unf;
    bit         chk_rd;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(bit w, logic [7:0] d, bit r, int cnt, bit ovf, bit unf,
                              bit chk_rd, logic [7:0] rd);
    vec_t v;
    v.w_en = w; v.w_data = d; v.r_en = r; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf; v.chk_rd = chk_rd; v.rd = rd;
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs();
    m_if.W_en = 1'b0; m_if.R_en = 1'b0; m_if.W_data = '0;
    f_if.W_en = 1'b0; f_if.R_en = 1'b0; f_if.W_data = '0;
  endtask

  task automatic m_write(input logic [7:0] d);
    m_if.W_en = 1'b1; m_if.W_data = d; m_if.R_en = 1'b0;
    step();
    m_if.W_en = 1'b0;
  endtask

  task automatic m_read();
    m_if.R_en = 1'b1; m_if.W_en = 1'b0;
    step();
    m_if.R_en = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst count", 32'(m_if.Count), 0);
    chk("rst empty", 32'(m_if.Empty), 1);
    chk("rst full", 32'(m_if.Full), 0);
    chk("rst ae", 32'(m_if.Almost_empty), 1);
    chk("rst af", 32'(m_if.Almost_full), 0);
    chk("rst rdata", 32'(m_if.R_data), 0);
    chk("rst ovf", 32'(m_if.Overflow), 0);
    chk("rst unf", 32'(m_if.Underflow), 0);
    rst = 1'b0;
    step();

    // Fill with 0..15, then an overflowing write.
    for (int k = 1; k <= 16; k++) add(1, 8'(k - 1), 0, k, 0, 0, 0, 0);
    add(1, 8'hEE, 0, 16, 1, 0, 0, 0);
    // Drain: data appears one cycle after each accepted read, then an underflowing read.
    for (int j = 1; j <= 16; j++) add(0, 0, 1, 16 - j, 0, 0, 1, 8'(j - 1));
    add(0, 0, 1, 0, 0, 1, 1, 8'd15);
    // Simultaneous read and write while empty: only the write is accepted.
    add(1, 8'h55, 1, 1, 0, 1, 1, 8'd15);
    for (int k = 0; k < 15; k++) add(1, 8'(8'h10 + k), 0, k + 2, 0, 0, 0, 0);
    // Simultaneous read and write while full: both accepted; 0x55 comes out and 0xAA goes in.
    add(1, 8'hAA, 1, 16, 0, 0, 1, 8'h55);
    for (int j = 0; j < 15; j++) add(0, 0, 1, 15 - j, 0, 0, 1, 8'(8'h10 + j));
    add(0, 0, 1, 0, 0, 0, 1, 8'hAA);

    for (int i = 0; i < vecs.size(); i++) begin
      m_if.W_en = vecs[i].w_en; m_if.W_data = vecs[i].w_data; m_if.R_en = vecs[i].r_en;
      step();
      chk($sformatf("v%0d count", i), 32'(m_if.Count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d empty", i), 32'(m_if.Empty), 32'(vecs[i].cnt == 0));
      chk($sformatf("v%0d full", i), 32'(m_if.Full), 32'(vecs[i].cnt == 16));
      chk($sformatf("v%0d ae", i), 32'(m_if.Almost_empty), 32'(vecs[i].cnt <= 4));
      chk($sformatf("v%0d af", i), 32'(m_if.Almost_full), 32'(vecs[i].cnt >= 12));
      chk($sformatf("v%0d ovf", i), 32'(m_if.Overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d unf", i), 32'(m_if.Underflow), 32'(vecs[i].unf));
      if (vecs[i].chk_rd) chk($sformatf("v%0d rdata", i), 32'(m_if.R_data), 32'(vecs[i].rd));
    end
    idle_inputs();

    // Three more fill/drain passes carry both pointers through wrap-bit toggles.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) m_write(8'(8'h40 + p * 16 + i));
      chk($sformatf("wrap%0d full", p), 32'(m_if.Full), 1);
      for (int i = 0; i < 16; i++) begin
        m_read();
        chk($sformatf("wrap%0d rd%0d", p, i), 32'(m_if.R_data), 32'(8'h40 + p * 16 + i));
      end
      chk($sformatf("wrap%0d empty", p), 32'(m_if.Empty), 1);
    end

    // Reset mid-stream with Count=7 and nonzero R_data.
    for (int i = 0; i < 8; i++) m_write(8'(8'h30 + i));
    m_read();
    chk("pre-rst count", 32'(m_if.Count), 7);
    chk("pre-rst rdata", 32'(m_if.R_data), 32'h30);
    rst = 1'b1;
    step();
    chk("mid-rst count", 32'(m_if.Count), 0);
    chk("mid-rst empty", 32'(m_if.Empty), 1);
    chk("mid-rst ae", 32'(m_if.Almost_empty), 1);
    chk("mid-rst rdata", 32'(m_if.R_data), 0);
    rst = 1'b0;
    step();
    m_write(8'h99);
    m_read();
    chk("post-rst rdata", 32'(m_if.R_data), 32'h99);
    chk("post-rst count", 32'(m_if.Count), 0);

    // FWFT instance: the head is visible without R_en, and R_data is 0 while empty.
    chk("fwft rst rdata", 32'(f_if.R_data), 0);
    f_if.W_en = 1'b1; f_if.W_data = 16'h1234;
    step();
    f_if.W_en = 1'b0;
    chk("fwft head", 32'(f_if.R_data), 32'h1234);
    chk("fwft nonempty", 32'(f_if.Empty), 0);
    f_if.W_en = 1'b1; f_if.W_data = 16'h5678;
    step();
    f_if.W_en = 1'b0;
    chk("fwft head hold", 32'(f_if.R_data), 32'h1234);
    chk("fwft count2", 32'(f_if.Count), 2);
    f_if.R_en = 1'b1;
    step();
    chk("fwft next head", 32'(f_if.R_data), 32'h5678);
    step();
    f_if.R_en = 1'b0;
    chk("fwft empty", 32'(f_if.Empty), 1);
    chk("fwft rdata0", 32'(f_if.R_data), 0);
    step();
    chk("fwft unf", 32'(f_if.Underflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
